// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package data_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_DBG  = 1'b1;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: on contention the port that was not
// granted last wins.
module rr_arbiter2
   import data_mem_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_gnt,
   output logic gnt_valid,
   output logic gnt_id
);

   always_comb begin
      gnt_valid = req0 | req1;
      gnt_id    = PORT_CORE;
      if (req0 && req1)
         gnt_id = ~last_gnt;
      else if (req1)
         gnt_id = PORT_DBG;
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one Data_Memory between the core load/store port (0) and the
// debug/DMA loader (1) with req/ack handshakes and a fixed access window.
module data_mem_arbiter
   import data_mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned ACC_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              dm_wr,
   output logic              dm_rd,
   output logic [ADDR_W-1:0] alu_out,
   output logic [DATA_W-1:0] crt,
   input  logic [DATA_W-1:0] data_rd,
   output logic              busy
);

   localparam logic [3:0] CNT_LAST = 4'(ACC_CYC - 1);

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   logic              last_gnt;
   logic              id_q;
   logic              we_q;
   logic              gnt_valid;
   logic              gnt_id;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_arbiter2 u_rr (
      .req0      (req0),
      .req1      (req1),
      .last_gnt  (last_gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   always_comb begin
      sel_we    = we0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
      if (gnt_id == PORT_DBG) begin
         sel_we    = we1;
         sel_addr  = addr1;
         sel_wdata = wdata1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_valid) state_nxt = ACCESS;
         ACCESS:  if (cnt == CNT_LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes and acks decode straight from the state register, so a reset
   // edge drops them in the same cycle as the state returns to IDLE.
   always_comb begin
      dm_wr = 1'b0;
      dm_rd = 1'b0;
      ack0  = 1'b0;
      ack1  = 1'b0;
      busy  = (state != IDLE);
      if (state == ACCESS) begin
         dm_wr = we_q;
         dm_rd = ~we_q;
      end
      if (state == DONE) begin
         ack0 = (id_q == PORT_CORE);
         ack1 = (id_q == PORT_DBG);
      end
   end

   // alu_out doubles as the latched address; crt only reloads for writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         last_gnt <= PORT_DBG;
         id_q     <= PORT_CORE;
         we_q     <= 1'b0;
         alu_out  <= '0;
         crt      <= '0;
         rdata    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_valid) begin
                  id_q     <= gnt_id;
                  last_gnt <= gnt_id;
                  we_q     <= sel_we;
                  alu_out  <= sel_addr;
                  if (sel_we)
                     crt <= sel_wdata;
                  cnt <= '0;
               end
            end
            ACCESS: begin
               cnt <= cnt + 4'd1;
               if (cnt == CNT_LAST && !we_q)
                  rdata <= data_rd;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: two instances (ACC_CYC=1 and 3), each with a
// memory model, checked against a transaction-level reference.
module tb_data_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mem_clr = 1'b1;
   always #5 clk = ~clk;

   logic        req0_v [2], we0_v [2], req1_v [2], we1_v [2];
   logic [31:0] addr0_v [2], wdata0_v [2], addr1_v [2], wdata1_v [2];
   logic        ack0_v [2], ack1_v [2], dmwr_v [2], dmrd_v [2], busy_v [2];
   logic [31:0] rdata_v [2], alu_v [2], crt_v [2], drd_v [2];

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [31:0] exp_mem [2][16];
   bit          last_port [2];
   bit          seen_acc [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [31:0] mem [16];
      data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ACC_CYC(g == 0 ? 1 : 3)) u_dut (
         .clk(clk), .rst(rst),
         .req0(req0_v[g]), .we0(we0_v[g]), .addr0(addr0_v[g]), .wdata0(wdata0_v[g]), .ack0(ack0_v[g]),
         .req1(req1_v[g]), .we1(we1_v[g]), .addr1(addr1_v[g]), .wdata1(wdata1_v[g]), .ack1(ack1_v[g]),
         .rdata(rdata_v[g]), .dm_wr(dmwr_v[g]), .dm_rd(dmrd_v[g]), .alu_out(alu_v[g]),
         .crt(crt_v[g]), .data_rd(drd_v[g]), .busy(busy_v[g])
      );
      assign drd_v[g] = mem[alu_v[g][3:0]];
      always @(posedge clk) begin
         if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
         end else if (dmwr_v[g] === 1'b1) begin
            mem[alu_v[g][3:0]] <= crt_v[g];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic int unsigned acc(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic logic ack_of(input int d, input bit p);
      return p ? ack1_v[d] : ack0_v[d];
   endfunction

   task automatic drive_port(input int d, input bit p, input bit r, input bit w,
                             input logic [31:0] a, input logic [31:0] wd);
      if (!p) begin
         req0_v[d] = r; we0_v[d] = w; addr0_v[d] = a; wdata0_v[d] = wd;
      end else begin
         req1_v[d] = r; we1_v[d] = w; addr1_v[d] = a; wdata1_v[d] = wd;
      end
   endtask

   // Invariants sampled every cycle on both instances.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            seen_acc[d] = 1'b0;
         end else begin
            chk1("wr_rd_excl", dmwr_v[d] & dmrd_v[d], 1'b0);
            chk1("ack_excl", ack0_v[d] & ack1_v[d], 1'b0);
            if (dmwr_v[d] | dmrd_v[d]) seen_acc[d] = 1'b1;
            if (ack0_v[d] | ack1_v[d]) begin
               chk1("ack_after_access", seen_acc[d], 1'b1);
               seen_acc[d] = 1'b0;
            end
         end
      end
   end

   // Single-requester transaction from an idle DUT; request fields are
   // scrambled once the access is under way to show they were latched.
   task automatic txn(input int d, input bit p, input bit we,
                      input logic [31:0] a, input logic [31:0] wd);
      int unsigned cyc = 0, nstb = 0, nbusy = 0;
      bit got = 0;
      logic [31:0] rd_seen;
      @(negedge clk);
      drive_port(d, p, 1'b1, we, a, wd);
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (busy_v[d]) nbusy++;
         chk1("other_ack_quiet", ack_of(d, ~p), 1'b0);
         if (dmwr_v[d] | dmrd_v[d]) begin
            nstb++;
            chk("txn_addr", alu_v[d], a);
            chk1("txn_dir", dmwr_v[d], we);
            if (we) chk("txn_wdata", crt_v[d], wd);
            drive_port(d, p, 1'b1, ~we, $urandom, $urandom);
         end
         if (ack_of(d, p)) got = 1;
      end
      drive_port(d, p, 1'b0, 1'b0, '0, '0);
      chk1("txn_ack_seen", got, 1'b1);
      chk("txn_latency", cyc, acc(d) + 1);
      chk("txn_strobe_cycles", nstb, acc(d));
      chk("txn_busy_cycles", nbusy, acc(d) + 1);
      if (!we) chk("txn_rdata", rdata_v[d], exp_mem[d][a[3:0]]);
      else exp_mem[d][a[3:0]] = wd;
      last_port[d] = p;
      rd_seen = rdata_v[d];
      @(negedge clk);
      chk1("txn_idle_after", busy_v[d], 1'b0);
      chk1("txn_ack_once", ack_of(d, p), 1'b0);
      chk("txn_rdata_hold", rdata_v[d], rd_seen);
   endtask

   // Both ports held high: port 0 writes, port 1 reads; each ack re-arms the
   // served port with fresh fields.
   task automatic hold(input int d, input int ntx, input logic [31:0] a0i,
                       input logic [31:0] wd0i, input logic [31:0] a1i);
      logic [31:0] a [2];
      logic [31:0] wd0;
      int unsigned done = 0, cyc = 0;
      bit exp_p;
      a[0] = a0i; a[1] = a1i; wd0 = wd0i;
      @(negedge clk);
      drive_port(d, 1'b0, 1'b1, 1'b1, a[0], wd0);
      drive_port(d, 1'b1, 1'b1, 1'b0, a[1], '0);
      while (done < ntx && cyc < ntx * (acc(d) + 3) + 10) begin
         @(negedge clk);
         cyc++;
         exp_p = ~last_port[d];
         if (dmwr_v[d] | dmrd_v[d]) begin
            chk("hold_addr", alu_v[d], a[exp_p]);
            chk1("hold_dir", dmwr_v[d], ~exp_p);
         end
         if (ack0_v[d] | ack1_v[d]) begin
            chk1("hold_grant_order", ack1_v[d], exp_p);
            if (!exp_p) begin
               exp_mem[d][a[0][3:0]] = wd0;
               a[0] = $urandom_range(15);
               wd0 = $urandom;
               drive_port(d, 1'b0, 1'b1, 1'b1, a[0], wd0);
            end else begin
               chk("hold_rdata", rdata_v[d], exp_mem[d][a[1][3:0]]);
               a[1] = $urandom_range(15);
               drive_port(d, 1'b1, 1'b1, 1'b0, a[1], '0);
            end
            last_port[d] = exp_p;
            done++;
         end
      end
      drive_port(d, 1'b0, 1'b0, 1'b0, '0, '0);
      drive_port(d, 1'b1, 1'b0, 1'b0, '0, '0);
      chk("hold_txn_count", done, ntx);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      last_port[0] = 1'b1;
      last_port[1] = 1'b1;
   endtask

   initial begin
      logic [31:0] wd;
      int unsigned guard;
      for (int d = 0; d < 2; d++) begin
         drive_port(d, 1'b0, 1'b0, 1'b0, '0, '0);
         drive_port(d, 1'b1, 1'b0, 1'b0, '0, '0);
         for (int i = 0; i < 16; i++) exp_mem[d][i] = '0;
      end
      do_reset();
      mem_clr = 1'b0;

      for (int d = 0; d < 2; d++) begin
         chk("rst_alu_out", alu_v[d], '0);
         chk("rst_crt", crt_v[d], '0);
         chk("rst_rdata", rdata_v[d], '0);
         chk1("rst_dm_wr", dmwr_v[d], 1'b0);
         chk1("rst_dm_rd", dmrd_v[d], 1'b0);
         chk1("rst_ack0", ack0_v[d], 1'b0);
         chk1("rst_ack1", ack1_v[d], 1'b0);
         chk1("rst_busy", busy_v[d], 1'b0);
      end

      // Directed write then read-back at addr 2 on both window lengths.
      for (int d = 0; d < 2; d++) begin
         txn(d, 1'b0, 1'b1, 32'd2, 32'hD);
         txn(d, 1'b0, 1'b0, 32'd2, 32'h0);
      end

      // Contention right after reset: port 0 (write 3/0x9) before port 1 (read 2).
      do_reset();
      hold(0, 6, 32'd3, 32'h9, 32'd2);

      for (int k = 0; k < 24; k++) begin
         txn(k % 2, 1'($urandom_range(1)), 1'($urandom_range(1)),
             $urandom_range(15), $urandom);
      end
      hold(0, 8, $urandom_range(15), $urandom, $urandom_range(15));
      hold(1, 4, $urandom_range(15), $urandom, $urandom_range(15));

      // Reset in the second ACCESS cycle of a 3-cycle write on port 0.
      wd = $urandom;
      @(negedge clk);
      drive_port(1, 1'b0, 1'b1, 1'b1, 32'd5, wd);
      guard = 0;
      while (dmwr_v[1] !== 1'b1 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      chk1("abort_strobe_seen", dmwr_v[1], 1'b1);
      @(negedge clk);
      rst = 1'b1;
      drive_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      chk1("abort_dm_wr", dmwr_v[1], 1'b0);
      chk1("abort_dm_rd", dmrd_v[1], 1'b0);
      chk1("abort_busy", busy_v[1], 1'b0);
      chk1("abort_ack0", ack0_v[1], 1'b0);
      rst = 1'b0;
      last_port[0] = 1'b1;
      last_port[1] = 1'b1;
      exp_mem[1][5] = wd;
      repeat (5) begin
         @(negedge clk);
         chk1("abort_no_ack0", ack0_v[1], 1'b0);
         chk1("abort_idle", busy_v[1], 1'b0);
      end
      hold(1, 2, $urandom_range(15), $urandom, 32'd5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Sequences and shares the single Data_Memory between two requesters: port 0 is the core load/store stage, port 1 is the debug/DMA loader.
- Owns the memory control strobes dm_wr and dm_rd, and drives the memory address (alu_out) and write-data (crt) inputs.
- Uses a req/ack handshake toward the requesters, round-robin arbitration and a fixed access window of ACC_CYC cycles.
- Guarantees dm_wr and dm_rd are never asserted together.

Parameters:
- ADDR_W, 32, width of the memory address (alu_out).
- DATA_W, 32, width of the memory data (crt, data_rd).
- ACC_CYC, 1, number of cycles a strobe is held per access; legal range is 1 to 15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  port 0 request; held high until ack0.
- we0  input  1  port 0 direction: 1 = write, 0 = read.
- addr0  input  ADDR_W  port 0 address.
- wdata0  input  DATA_W  port 0 write data.
- ack0  output  1  one-cycle completion pulse for port 0.
- req1, we1, addr1, wdata1, ack1  as port 0, for port 1.
- rdata  output  DATA_W  read data; valid in the ack cycle and held until the next read completes.
- dm_wr  output  1  memory write strobe.
- dm_rd  output  1  memory read strobe.
- alu_out  output  ADDR_W  memory address.
- crt  output  DATA_W  memory write data.
- data_rd  input  DATA_W  memory read data.
- busy  output  1  high in ACCESS or DONE.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - state=IDLE, cycle counter=0, last_gnt=1 (so port 0 wins first);
  - dm_wr=0, dm_rd=0, alu_out=0, crt=0, rdata=0, ack0=0, ack1=0, busy=0.
- Reset mid-ACCESS or mid-DONE:
  - aborts the transaction; strobes and ack drop at that edge;
  - the aborted transaction is never acked; the requester reissues it.
- IDLE state:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the port != last_gnt.
  - On grant, latch we/addr/wdata and the granted id into registers, set last_gnt=id, go to ACCESS, counter=0.
- ACCESS state:
  - alu_out=latched addr, crt=latched wdata (write only; crt unchanged on a read).
  - dm_wr=latched we, dm_rd=!latched we, held for exactly ACC_CYC cycles.
  - Counter increments each cycle; on counter==ACC_CYC-1 go to DONE.
  - For a read, rdata captures data_rd on that same last edge.
- DONE state:
  - Strobes are 0; alu_out and crt hold their values.
  - ack<granted id>=1 for exactly this one cycle; next state is IDLE unconditionally.
- Latency: req sampled in IDLE at cycle T → strobes in T+1..T+ACC_CYC → ack at T+ACC_CYC+1.
  - A back-to-back transaction from the same port re-arbitrates in the IDLE cycle T+ACC_CYC+2.
- Requester rules:
  - req may stay high after ack; this is treated as a new request.
  - Fields are sampled only at the grant edge. Changes, or a req drop, after grant do not affect the in-flight transaction, which completes and acks.
- Fairness: with both reqs held continuously, grants strictly alternate 0,1,0,1.
- Invariants:
  - dm_wr & dm_rd == 0 always.
  - ack0 & ack1 == 0 always.
  - No ack is issued without a preceding ACCESS window.
- Width rules: no arithmetic on address or data; the counter is 4 bits.

Decomposition:
- Package data_mem_pkg holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2);
  - port id constants PORT_CORE=1'b0, PORT_DBG=1'b1;
  - default widths ADDR_W_DEF=32, DATA_W_DEF=32.
- One natural sub-module, rr_arbiter2:
  - combinational 2-way round-robin pick from (req0, req1, last_gnt);
  - outputs gnt_valid and gnt_id.
- The FSM, latches and counter stay in data_mem_arbiter.

Test Plan:
- Port 0 write: after reset, req0=1, we0=1, addr0=2, wdata0=0xD (ACC_CYC=1).
  - dm_wr=1 with alu_out=2, crt=0xD for 1 cycle; ack0 the next cycle; dm_rd=0 throughout.
- Port 0 read-back: req0=1, we0=0, addr0=2, with a memory model attached.
  - dm_rd=1 for 1 cycle; rdata=0xD in the ack0 cycle and held afterwards.
- Simultaneous requests after reset: port 0 writes addr 3 / 0x9, port 1 reads addr 2.
  - Port 0 is served first (ack0); port 1 is served next (ack1, rdata=0xD).
  - The grant order is verified by alu_out sequence 3 then 2.
- Both reqs held high for 6 transactions.
  - Grant sequence is exactly 0,1,0,1,0,1; no cycle ever has dm_wr&dm_rd or ack0&ack1.
- ACC_CYC=3 read at addr 2.
  - dm_rd is high for exactly 3 cycles; ack is at T+4; busy is high for 4 cycles.
  - A change to addr0 during ACCESS does not change alu_out.
- rst=1 in the 2nd ACCESS cycle of an ACC_CYC=3 write.
  - Strobes are 0 at the next edge; no ack0 is issued; state is IDLE.
  - Re-requesting port 1 vs port 0 simultaneously grants port 0 first (last_gnt=1).
